// File: rtl/rggen_bit_field_access_arbiter.sv
// Arbitrates several requesters onto a single bit-field access port.
// One access is in flight at a time: IDLE -> ACCESS -> RESPONSE -> IDLE.
// Default build grants round-robin; define RGGEN_BIT_FIELD_ARBITER_FIXED_PRIORITY_EN
// to grant the lowest-index valid requester instead.
module rggen_bit_field_access_arbiter #(
    parameter int WIDTH      = 32,
    parameter int REQUESTERS = 2
)(
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [REQUESTERS-1:0]       i_request_valid,
    input  logic [REQUESTERS-1:0]       i_request_write,
    input  logic [REQUESTERS*WIDTH-1:0] i_request_mask,
    input  logic [REQUESTERS*WIDTH-1:0] i_request_write_data,
    output logic [REQUESTERS-1:0]       o_request_ready,
    output logic [REQUESTERS-1:0]       o_response_valid,
    input  logic [REQUESTERS-1:0]       i_response_ready,
    output logic [WIDTH-1:0]            o_response_read_data,
    output logic                        o_bit_field_valid,
    output logic [WIDTH-1:0]            o_bit_field_read_mask,
    output logic [WIDTH-1:0]            o_bit_field_write_mask,
    output logic [WIDTH-1:0]            o_bit_field_write_data,
    input  logic [WIDTH-1:0]            i_bit_field_read_data
);

    localparam int GW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] ACCESS   = 2'd1;
    localparam logic [1:0] RESPONSE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [GW-1:0]    grant_q, grant_d;
    logic             write_q, write_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;

    logic             any_valid;
    logic             found;
    logic [GW-1:0]    sel;

`ifdef RGGEN_BIT_FIELD_ARBITER_FIXED_PRIORITY_EN
    // Fixed priority: lowest-index valid requester wins
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int unsigned i = 0; i < REQUESTERS; i++) begin
            if (!found && i_request_valid[i]) begin
                found = 1'b1;
                sel   = GW'(i);
            end
        end
    end
`else
    logic [GW-1:0]    ptr_q, ptr_d;
    int unsigned      rr_idx;

    // Round-robin: first valid requester at or after the pointer, wrapping
    always_comb begin
        found  = 1'b0;
        sel    = '0;
        rr_idx = 0;
        for (int unsigned i = 0; i < REQUESTERS; i++) begin
            rr_idx = (32'(ptr_q) + i) % REQUESTERS;
            if (!found && i_request_valid[rr_idx]) begin
                found = 1'b1;
                sel   = GW'(rr_idx);
            end
        end
    end
`endif

    assign any_valid = |i_request_valid;

    // Next-state logic: latch the winning command, capture read data, wait for consumption
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        write_d = write_q;
        mask_d  = mask_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
`ifndef RGGEN_BIT_FIELD_ARBITER_FIXED_PRIORITY_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    state_d = ACCESS;
                    grant_d = sel;
                    write_d = i_request_write[sel];
                    mask_d  = i_request_mask[32'(sel)*WIDTH +: WIDTH];
                    wdata_d = i_request_write_data[32'(sel)*WIDTH +: WIDTH];
`ifndef RGGEN_BIT_FIELD_ARBITER_FIXED_PRIORITY_EN
                    ptr_d   = (sel == GW'(REQUESTERS - 1)) ? '0 : sel + GW'(1);
`endif
                end
            end
            ACCESS: begin
                state_d = RESPONSE;
                rdata_d = write_q ? '0 : i_bit_field_read_data;
            end
            RESPONSE: begin
                if (i_response_ready[grant_q]) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            write_q <= 1'b0;
            mask_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifndef RGGEN_BIT_FIELD_ARBITER_FIXED_PRIORITY_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            write_q <= write_d;
            mask_q  <= mask_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifndef RGGEN_BIT_FIELD_ARBITER_FIXED_PRIORITY_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    // Output decode; everything is forced low while reset is asserted
    always_comb begin
        o_request_ready        = '0;
        o_response_valid       = '0;
        o_response_read_data   = '0;
        o_bit_field_valid      = 1'b0;
        o_bit_field_read_mask  = '0;
        o_bit_field_write_mask = '0;
        o_bit_field_write_data = '0;
        if (!i_rst) begin
            case (state_q)
                IDLE: begin
                    if (any_valid) begin
                        o_request_ready[sel] = 1'b1;
                    end
                end
                ACCESS: begin
                    o_bit_field_valid      = 1'b1;
                    o_bit_field_read_mask  = write_q ? '0 : mask_q;
                    o_bit_field_write_mask = write_q ? mask_q : '0;
                    o_bit_field_write_data = write_q ? wdata_q : '0;
                end
                RESPONSE: begin
                    o_response_valid[grant_q] = 1'b1;
                    o_response_read_data      = rdata_q;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/rggen_bit_field_access_arbiter.md
RGGEN_BIT_FIELD_ACCESS_ARBITER -- requirements
Module: rggen_bit_field_access_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, bit-field data/mask width.
REQ-002 SHALL have parameter REQUESTERS, default 2, number of requesters (N), N >= 2.
REQ-003 SHALL have i_clk  input  1  clock; single clock domain, all state on rising edge.
REQ-004 SHALL have i_rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have i_request_valid  input  N  per-requester access request.
REQ-006 SHALL have i_request_write  input  N  per-requester access type, 1 = write, 0 = read.
REQ-007 SHALL have i_request_mask  input  N*WIDTH  per-requester bit mask, requester k at [k*WIDTH +: WIDTH].
REQ-008 SHALL have i_request_write_data  input  N*WIDTH  per-requester write data, same packing.
REQ-009 SHALL have o_request_ready  output  N  request accepted when valid and ready in the same cycle.
REQ-010 SHALL have o_response_valid  output  N  response pending for requester k.
REQ-011 SHALL have i_response_ready  input  N  requester k consumes the response.
REQ-012 SHALL have o_response_read_data  output  WIDTH  read data, shared by all requesters.
REQ-013 SHALL have o_bit_field_valid, o_bit_field_read_mask, o_bit_field_write_mask, o_bit_field_write_data  output  1/WIDTH/WIDTH/WIDTH  bit-field access.
REQ-014 SHALL have i_bit_field_read_data  input  WIDTH  read data returned by the bit field.

Function
REQ-015 SHALL implement the FSM IDLE -> ACCESS -> RESPONSE -> IDLE, one access in flight.
REQ-016 In IDLE with any valid request, SHALL assert o_request_ready only for the selected requester (REQ-025), latch its type/mask/data and grant index, and go to ACCESS.
REQ-017 SHALL keep o_request_ready all-zero in ACCESS and RESPONSE, and in IDLE when no request is valid.
REQ-018 In ACCESS, SHALL assert o_bit_field_valid for exactly one cycle and go to RESPONSE.
REQ-019 For a write, SHALL drive write_mask = mask, read_mask = 0, write_data = latched data.
REQ-020 For a read, SHALL drive read_mask = mask, write_mask = 0, write_data = 0.
REQ-021 SHALL drive all o_bit_field_* outputs to 0 outside ACCESS.
REQ-022 SHALL capture i_bit_field_read_data at the end of the ACCESS cycle for reads, and capture 0 for writes.
REQ-023 In RESPONSE, SHALL hold o_response_valid[grant] = 1 and the captured data until i_response_ready[grant] = 1, then go to IDLE; all other bits of o_response_valid and i_response_ready SHALL be 0 and ignored respectively.
REQ-024 Latency: request accepted in cycle T, access in T+1, response valid from T+2; back-to-back accept no earlier than the cycle after the response handshake.
REQ-025 Round-robin: search starts at pointer P and wraps modulo N; after each accept, P = grant+1 (mod N, N-1 wraps to 0).
REQ-026 A requester dropping valid before being accepted SHALL NOT be granted and SHALL NOT move P.

Reset
REQ-027 When i_rst = 1 at a clock edge, SHALL enter IDLE and set P = 0; read-data register and all latched command fields SHALL be 0.
REQ-028 Reset mid-access or mid-response SHALL abort and discard the transaction; no o_bit_field_valid or o_response_valid SHALL appear afterwards for it.
REQ-029 During and immediately after reset, all outputs SHALL be 0.

Configuration
REQ-030 With RGGEN_BIT_FIELD_ARBITER_FIXED_PRIORITY_EN defined, SHALL grant the lowest-index valid requester, and P SHALL be unused.
REQ-031 Without RGGEN_BIT_FIELD_ARBITER_FIXED_PRIORITY_EN, SHALL use round-robin per REQ-025.

Verification (N=2, WIDTH=8)
REQ-032 Req0 write, mask 0x0F, data 0xA5 -> ready0 at T; at T+1 valid=1, write_mask 0x0F, read_mask 0x00, write_data 0xA5; at T+2 response_valid0=1, read_data 0x00.
REQ-033 Req1 read, mask 0xFF, bit field returns 0x3C at T+1 -> at T+1 read_mask 0xFF, write_mask 0; response_valid1 with read_data 0x3C held until response_ready1.
REQ-034 Both valid continuously, round-robin build -> grants alternate 0,1,0,1; with fixed-priority macro -> grants 0,0,0,0.
REQ-035 response_ready1 held 0 for 5 cycles -> response_valid1 and read_data stay stable; ready0/ready1 stay 0 throughout.
REQ-036 i_rst asserted during ACCESS -> next cycle all outputs 0, no response issued; after release, first grant with both valid goes to req0.
